// File: rtl/edge_ctrl_pkg.sv
// Shared register map, STATUS bit positions and controller state encoding
// for the EdgeDetector sequencing controller.
package edge_ctrl_pkg;

   localparam logic [1:0] REG_CTRL      = 2'd0;
   localparam logic [1:0] REG_STATUS    = 2'd1;
   localparam logic [1:0] REG_PIXEL_IN  = 2'd2;
   localparam logic [1:0] REG_PIXEL_OUT = 2'd3;

   localparam int unsigned CTRL_START_BIT = 0;
   localparam int unsigned CTRL_CLEAR_BIT = 1;

   localparam int unsigned STAT_BUSY_BIT      = 0;
   localparam int unsigned STAT_DONE_BIT      = 1;
   localparam int unsigned STAT_IN_FULL_BIT   = 2;
   localparam int unsigned STAT_OVERFLOW_BIT  = 3;
   localparam int unsigned STAT_TIMEOUT_BIT   = 4;
   localparam int unsigned STAT_START_ERR_BIT = 5;
   localparam int unsigned STAT_DET_AVAIL_BIT = 6;
   localparam int unsigned STAT_COUNT_LSB     = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } ctrl_state_e;

endpackage

// File: rtl/edge_pixel_buf.sv
// 8-bit pixel buffer: count tracks pixels written, rd_ptr walks them back out
// independently so the same contents can be replayed after a rewind.
module edge_pixel_buf #(
   parameter int unsigned DEPTH = 9,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr,
   input  logic          rewind,
   input  logic          push,
   input  logic [7:0]    wdata,
   input  logic          pop,
   output logic [7:0]    rd_data,
   output logic [CW-1:0] count,
   output logic [CW-1:0] rd_ptr
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0] mem [0:(2**AW)-1];
   logic       full;

   assign full    = (count == CW'(DEPTH));
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (push && !full && !clr) begin
         mem[count[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count  <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         count  <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            count <= count + 1'b1;
         end
         if (rewind) begin
            rd_ptr <= '0;
         end else if (pop && (rd_ptr < count)) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/edge_detector_ctrl.sv
// Avalon-MM controller that loads an image, streams it through one EdgeDetector
// instance at one pixel per clock and captures the valid output pixels.
module edge_detector_ctrl
   import edge_ctrl_pkg::*;
#(
   parameter int unsigned KX_SIZE       = 3,
   parameter int unsigned KY_SIZE       = 3,
   parameter int unsigned IMG_X_SIZE    = 3,
   parameter int unsigned IMG_Y_SIZE    = 3,
   parameter int unsigned DRAIN_TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  avs_address_i,
   input  logic        avs_write_i,
   input  logic [31:0] avs_writedata_i,
   input  logic        avs_read_i,
   output logic [31:0] avs_readdata_o,
   output logic        irq_o,
   output logic        det_start_o,
   output logic [7:0]  det_pixel_o,
   input  logic        det_valid_i,
   input  logic        det_data_avail_i,
   input  logic [7:0]  det_pixel_i
);

   localparam int unsigned N_IN   = IMG_X_SIZE * IMG_Y_SIZE;
   localparam int unsigned N_OUT  = (IMG_X_SIZE - KX_SIZE + 1) * (IMG_Y_SIZE - KY_SIZE + 1);
   localparam int unsigned IN_CW  = $clog2(N_IN + 1);
   localparam int unsigned OUT_CW = $clog2(N_OUT + 1);
   localparam int unsigned TW     = $clog2(DRAIN_TIMEOUT + 1);

   ctrl_state_e state_q, state_d;

   logic [IN_CW-1:0]  in_count, in_rptr;
   logic [OUT_CW-1:0] out_count, out_rptr;
   logic [7:0]        in_rd_data, out_rd_data;
   logic [TW-1:0]     idle_q;
   logic [7:0]        pix_hold_q;
   logic              done_q, ovf_q, tmo_q, serr_q;

   logic        idle, in_full, out_avail;
   logic        wr_ctrl, wr_pix, rd_out;
   logic        clr_req, start_req, capture;
   logic        drain_full, drain_tmo;
   logic [31:0] status_word, read_word;
   logic        unused_wdata;

   assign unused_wdata = ^avs_writedata_i[31:8];

   assign idle      = (state_q == ST_IDLE);
   assign in_full   = (in_count == IN_CW'(N_IN));
   assign out_avail = (out_rptr < out_count);

   assign wr_ctrl   = avs_write_i && (avs_address_i == REG_CTRL);
   assign wr_pix    = avs_write_i && (avs_address_i == REG_PIXEL_IN);
   assign rd_out    = avs_read_i && (avs_address_i == REG_PIXEL_OUT);
   assign clr_req   = wr_ctrl && idle && avs_writedata_i[CTRL_CLEAR_BIT];
   assign start_req = wr_ctrl && idle && avs_writedata_i[CTRL_START_BIT]
                      && !avs_writedata_i[CTRL_CLEAR_BIT];
   assign capture   = det_valid_i && ((state_q == ST_FEED) || (state_q == ST_DRAIN));

   // A capture this cycle counts toward completion, so DONE follows it directly.
   assign drain_full = (state_q == ST_DRAIN) &&
                       ((out_count == OUT_CW'(N_OUT)) ||
                        (det_valid_i && (out_count == OUT_CW'(N_OUT - 1))));
   assign drain_tmo  = (state_q == ST_DRAIN) && !drain_full && !det_valid_i &&
                       (idle_q == TW'(DRAIN_TIMEOUT - 1));

   assign det_pixel_o = (state_q == ST_FEED) ? in_rd_data : pix_hold_q;
   assign irq_o       = done_q;

   edge_pixel_buf #(.DEPTH(N_IN)) u_in_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr     (clr_req),
      .rewind  (state_q == ST_START),
      .push    (wr_pix && idle),
      .wdata   (avs_writedata_i[7:0]),
      .pop     (state_q == ST_FEED),
      .rd_data (in_rd_data),
      .count   (in_count),
      .rd_ptr  (in_rptr)
   );

   edge_pixel_buf #(.DEPTH(N_OUT)) u_out_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr     (clr_req),
      .rewind  (1'b0),
      .push    (capture),
      .wdata   (det_pixel_i),
      .pop     (rd_out),
      .rd_data (out_rd_data),
      .count   (out_count),
      .rd_ptr  (out_rptr)
   );

   always_comb begin
      state_d     = state_q;
      det_start_o = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (start_req && in_full) state_d = ST_START;
         ST_START: begin
            det_start_o = 1'b1;
            state_d     = ST_FEED;
         end
         ST_FEED:  if (in_rptr == IN_CW'(N_IN - 1)) state_d = ST_DRAIN;
         ST_DRAIN: if (drain_full || drain_tmo) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      status_word                      = '0;
      status_word[STAT_BUSY_BIT]       = !idle;
      status_word[STAT_DONE_BIT]       = done_q;
      status_word[STAT_IN_FULL_BIT]    = in_full;
      status_word[STAT_OVERFLOW_BIT]   = ovf_q;
      status_word[STAT_TIMEOUT_BIT]    = tmo_q;
      status_word[STAT_START_ERR_BIT]  = serr_q;
      status_word[STAT_DET_AVAIL_BIT]  = det_data_avail_i;
      status_word[STAT_COUNT_LSB +: 8] = 8'(out_count);

      read_word = '0;
      unique case (avs_address_i)
         REG_STATUS:    read_word = status_word;
         REG_PIXEL_OUT: read_word = {24'd0, (out_avail ? out_rd_data : 8'd0)};
         default:       read_word = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q        <= ST_IDLE;
         idle_q         <= '0;
         pix_hold_q     <= '0;
         done_q         <= 1'b0;
         ovf_q          <= 1'b0;
         tmo_q          <= 1'b0;
         serr_q         <= 1'b0;
         avs_readdata_o <= '0;
      end else begin
         state_q <= state_d;

         if (clr_req) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            tmo_q  <= 1'b0;
            serr_q <= 1'b0;
         end else begin
            if (start_req && !in_full) serr_q <= 1'b1;
            if (wr_pix && idle && in_full) ovf_q <= 1'b1;
            if (state_d == ST_DONE) done_q <= 1'b1;
            if (drain_tmo) tmo_q <= 1'b1;
         end

         if ((state_q != ST_DRAIN) || det_valid_i) begin
            idle_q <= '0;
         end else begin
            idle_q <= idle_q + 1'b1;
         end

         if (state_q == ST_FEED) pix_hold_q <= in_rd_data;

         if (avs_read_i) avs_readdata_o <= read_word;
      end
   end

endmodule

// File: tb/tb_edge_detector_ctrl.sv
// Randomised scoreboard bench for edge_detector_ctrl with a behavioural host
// model and a simple detector response model.
module tb_edge_detector_ctrl;

   localparam int N_IN          = 9;
   localparam int N_OUT         = 1;
   localparam int DRAIN_TIMEOUT = 64;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [1:0]  avs_address_i = '0;
   logic        avs_write_i = 1'b0;
   logic [31:0] avs_writedata_i = '0;
   logic        avs_read_i = 1'b0;
   logic [31:0] avs_readdata_o;
   logic        irq_o;
   logic        det_start_o;
   logic [7:0]  det_pixel_o;
   logic        det_valid_i = 1'b0;
   logic        det_data_avail_i = 1'b0;
   logic [7:0]  det_pixel_i = '0;

   edge_detector_ctrl #(
      .KX_SIZE(3), .KY_SIZE(3), .IMG_X_SIZE(3), .IMG_Y_SIZE(3), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .avs_address_i(avs_address_i), .avs_write_i(avs_write_i),
      .avs_writedata_i(avs_writedata_i), .avs_read_i(avs_read_i),
      .avs_readdata_o(avs_readdata_o), .irq_o(irq_o),
      .det_start_o(det_start_o), .det_pixel_o(det_pixel_o),
      .det_valid_i(det_valid_i), .det_data_avail_i(det_data_avail_i),
      .det_pixel_i(det_pixel_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Host-visible reference state
   logic [7:0] mdl_in[$];
   logic [7:0] mdl_out[$];
   int         m_rd = 0;
   bit         m_done = 0, m_ovf = 0, m_tmo = 0, m_serr = 0;

   function automatic logic [31:0] exp_status(input bit busy);
      logic [31:0] s;
      s        = '0;
      s[0]     = busy;
      s[1]     = m_done;
      s[2]     = (mdl_in.size() == N_IN);
      s[3]     = m_ovf;
      s[4]     = m_tmo;
      s[5]     = m_serr;
      s[6]     = det_data_avail_i;
      s[23:16] = 8'(mdl_out.size());
      return s;
   endfunction

   function automatic void mdl_reset();
      mdl_in.delete();
      mdl_out.delete();
      m_rd = 0;
      m_done = 0; m_ovf = 0; m_tmo = 0; m_serr = 0;
   endfunction

   // Read scoreboard: expectations queued at issue, compared when data appears
   logic [31:0] rd_exp_q[$];
   string       rd_name_q[$];
   logic        rd_fire = 1'b0;

   always @(posedge clk_i) rd_fire <= avs_read_i;

   always @(negedge clk_i) begin
      if (rd_fire) begin
         if (rd_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got 0x%08h with no expectation", avs_readdata_o);
         end else begin
            check(rd_name_q.pop_front(), avs_readdata_o, rd_exp_q.pop_front());
         end
      end
   end

   // Detector-side monitor: start pulse width, pixel stream, hold after stream
   logic [7:0] feed_exp[$];
   int         feed_idx = -1;
   int         start_pulses = 0;
   int         exp_pulses = 0;

   always @(negedge clk_i) begin
      if (!rst_i) begin
         feed_idx = -1;
      end else begin
         if (feed_idx >= 0) begin
            if (feed_idx == 0) check("start_width", {31'd0, det_start_o}, 32'd0);
            check($sformatf("feed_pix%0d", feed_idx), {24'd0, det_pixel_o},
                  {24'd0, feed_exp[(feed_idx < N_IN) ? feed_idx : N_IN - 1]});
            feed_idx++;
            if (feed_idx > N_IN) feed_idx = -1;
         end
         if (det_start_o) begin
            start_pulses++;
            feed_idx = 0;
         end
      end
   end

   logic irq_prev = 1'b0;
   bit   irq_seen = 0;
   int   irq_cyc = 0;

   always @(negedge clk_i) begin
      if (irq_o && !irq_prev) begin
         irq_seen = 1;
         irq_cyc  = cyc;
      end
      irq_prev = irq_o;
   end

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input bit busy);
      avs_address_i   = a;
      avs_writedata_i = d;
      avs_write_i     = 1'b1;
      @(posedge clk_i); #1;
      avs_write_i = 1'b0;
      if (!busy) begin
         if (a == 2'd0) begin
            if (d[1]) mdl_reset_flags_and_bufs();
            else if (d[0] && mdl_in.size() != N_IN) m_serr = 1;
         end else if (a == 2'd2) begin
            if (mdl_in.size() == N_IN) m_ovf = 1;
            else mdl_in.push_back(d[7:0]);
         end
      end
   endtask

   function automatic void mdl_reset_flags_and_bufs();
      mdl_reset();
   endfunction

   task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      rd_exp_q.push_back(exp);
      rd_name_q.push_back(name);
      avs_address_i = a;
      avs_read_i    = 1'b1;
      @(posedge clk_i); #1;
      avs_read_i = 1'b0;
   endtask

   task automatic rd_pixel_out(input string name);
      logic [31:0] e;
      e = '0;
      if (m_rd < mdl_out.size()) begin
         e = {24'd0, mdl_out[m_rd]};
         m_rd++;
      end
      bus_rd(2'd3, e, name);
   endtask

   task automatic load_image(input bit ramp);
      for (int i = 0; i < N_IN; i++) bus_wr(2'd2, ramp ? 32'(i + 1) : 32'($urandom_range(0, 255)), 0);
   endtask

   // One full sequence: quiet=1 means the detector never reports a valid pixel
   task automatic run_image(input int d, input int burst, input bit quiet, input bit poke);
      int       t, v, exp_done, n;
      logic [7:0] cap;
      v   = 0;
      cap = '0;
      feed_exp = mdl_in;
      irq_seen = 0;
      t = cyc;
      exp_pulses++;
      bus_wr(2'd0, 32'd1, 0);
      fork
         begin
            if (!quiet) begin
               repeat (d) @(posedge clk_i);
               #1;
               v = cyc;
               for (int i = 0; i < burst; i++) begin
                  det_valid_i = 1'b1;
                  det_pixel_i = 8'($urandom_range(0, 255));
                  if (i == 0) cap = det_pixel_i;
                  @(posedge clk_i); #1;
               end
               det_valid_i = 1'b0;
            end
         end
         begin
            if (poke) begin
               @(posedge clk_i); #1;
               bus_wr(2'd2, 32'h000000AA, 1);
               bus_wr(2'd0, 32'd1, 1);
               bus_wr(2'd0, 32'd2, 1);
               bus_rd(2'd1, exp_status(1), "status_busy");
               bus_wr(2'd0, 32'd3, 1);
            end
         end
      join
      exp_done = quiet ? t + N_IN + 2 + DRAIN_TIMEOUT
                       : (((v > t + N_IN + 2) ? v : t + N_IN + 2) + 1);
      n = 0;
      while (!irq_seen && n < 400) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("irq_rise", {31'd0, irq_seen}, 32'd1);
      if (irq_seen) check("done_cycle", irq_cyc - t, exp_done - t);
      check("start_pulses", start_pulses, exp_pulses);
      m_done = 1;
      if (quiet) m_tmo = 1;
      else if (mdl_out.size() < N_OUT) mdl_out.push_back(cap);
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_readdata", avs_readdata_o, 32'd0);
      check("rst_irq", {31'd0, irq_o}, 32'd0);
      check("rst_det_start", {31'd0, det_start_o}, 32'd0);
      check("rst_det_pixel", {24'd0, det_pixel_o}, 32'd0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      bus_rd(2'd1, exp_status(0), "status_reset");

      // Ramp image, one valid pixel, then two pops
      load_image(1);
      run_image(12, 1, 0, 0);
      bus_rd(2'd1, exp_status(0), "status_run1");
      rd_pixel_out("pixout_first");
      rd_pixel_out("pixout_empty");

      // Start+clear together: clear wins
      bus_wr(2'd0, 32'd3, 0);
      repeat (3) @(posedge clk_i);
      #1;
      check("no_start_on_clear", start_pulses, exp_pulses);
      bus_rd(2'd1, exp_status(0), "status_clear");

      // Partial load then start, then overflow past the full image
      for (int i = 0; i < 5; i++) bus_wr(2'd2, 32'(i + 1), 0);
      bus_wr(2'd0, 32'd1, 0);
      repeat (3) @(posedge clk_i);
      #1;
      check("no_start_partial", start_pulses, exp_pulses);
      bus_rd(2'd1, exp_status(0), "status_start_err");
      for (int i = 5; i < N_IN; i++) bus_wr(2'd2, 32'(i + 1), 0);
      bus_wr(2'd2, 32'd77, 0);
      bus_rd(2'd1, exp_status(0), "status_overflow");
      run_image(3, 3, 0, 0);
      bus_rd(2'd1, exp_status(0), "status_run_ovf");

      // Detector silent: timeout
      bus_wr(2'd0, 32'd2, 0);
      load_image(0);
      run_image(0, 0, 1, 0);
      bus_rd(2'd1, exp_status(0), "status_timeout");
      rd_pixel_out("pixout_timeout");

      // Bus activity while busy is ignored
      bus_wr(2'd0, 32'd2, 0);
      load_image(0);
      run_image(14, 2, 0, 1);
      bus_rd(2'd1, exp_status(0), "status_poked");
      rd_pixel_out("pixout_poked");
      bus_wr(2'd0, 32'd2, 0);
      bus_rd(2'd1, exp_status(0), "status_idle_clear");

      // Randomised runs
      for (int r = 0; r < 4; r++) begin
         bus_wr(2'd0, 32'd2, 0);
         det_data_avail_i = 1'($urandom_range(0, 1));
         load_image(0);
         run_image($urandom_range(1, N_IN + 20), $urandom_range(1, 3), 0, 0);
         bus_rd(2'd1, exp_status(0), $sformatf("status_rand%0d", r));
         rd_pixel_out($sformatf("pixout_rand%0d", r));
         rd_pixel_out($sformatf("pixout_rand%0d_empty", r));
      end

      // Reset during FEED, then reload and rerun
      bus_rd(2'd1, exp_status(0), "status_pre_reset");
      feed_exp = mdl_in;
      exp_pulses++;
      bus_wr(2'd0, 32'd1, 0);
      repeat (4) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #2;
      check("midrst_readdata", avs_readdata_o, 32'd0);
      check("midrst_irq", {31'd0, irq_o}, 32'd0);
      check("midrst_det_start", {31'd0, det_start_o}, 32'd0);
      check("midrst_det_pixel", {24'd0, det_pixel_o}, 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      mdl_reset();
      det_data_avail_i = 1'b0;
      bus_rd(2'd1, exp_status(0), "status_after_reset");
      load_image(0);
      run_image(6, 1, 0, 0);
      bus_rd(2'd1, exp_status(0), "status_after_rerun");
      rd_pixel_out("pixout_after_rerun");

      repeat (4) @(posedge clk_i);
      #1;
      check("read_queue_drained", rd_exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
